// File: rtl/bp_io_scratch_responder_pkg.sv
// bp_io_scratch_responder_pkg: BP memory-message types shared by the I/O
// scratch responder, its interface, its register file and its testbench.
// Also provides the DECLARE_BP_MEM_MSG_S macro. The macro builds the
// parameterised message struct: data | payload | size | addr | msg_type.
package bp_io_scratch_responder_pkg;

    // Opaque payload carried in every message header.
    localparam int mem_payload_width_gp = 16;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3,
        e_mem_msg_pre   = 4'd4,
        e_mem_msg_amo   = 4'd5
    } bp_mem_msg_e;

    typedef enum logic [1:0] {
        e_mem_size_1 = 2'd0,
        e_mem_size_2 = 2'd1,
        e_mem_size_4 = 2'd2,
        e_mem_size_8 = 2'd3
    } bp_mem_msg_size_e;

    // Total message width: header plus data field.
    function automatic int mem_msg_width(int paddr_width, int data_width);
        return $bits(bp_mem_msg_e) + paddr_width + $bits(bp_mem_msg_size_e)
             + mem_payload_width_gp + data_width;
    endfunction

    function automatic logic is_read_class(bp_mem_msg_e t);
        return (t == e_mem_msg_rd) || (t == e_mem_msg_uc_rd);
    endfunction

    // Only true writes modify state; unknown types are write-class but inert.
    function automatic logic is_write_type(bp_mem_msg_e t);
        return (t == e_mem_msg_wr) || (t == e_mem_msg_uc_wr);
    endfunction

    // Low 'size' bytes set.
    function automatic logic [7:0] size_byte_mask(bp_mem_msg_size_e size);
        case (size)
            e_mem_size_1: return 8'h01;
            e_mem_size_2: return 8'h03;
            e_mem_size_4: return 8'h0F;
            default:      return 8'hFF;
        endcase
    endfunction

    // Clears the low log2(size) offset bits so misaligned accesses align down.
    function automatic logic [2:0] offset_align_mask(bp_mem_msg_size_e size);
        case (size)
            e_mem_size_1: return 3'b111;
            e_mem_size_2: return 3'b110;
            e_mem_size_4: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] expand_byte_mask(logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

endpackage

`define DECLARE_BP_MEM_MSG_S(paddr_width_mp, data_width_mp) \
    typedef struct packed { \
        logic [data_width_mp-1:0] data; \
        logic [bp_io_scratch_responder_pkg::mem_payload_width_gp-1:0] payload; \
        bp_io_scratch_responder_pkg::bp_mem_msg_size_e size; \
        logic [paddr_width_mp-1:0] addr; \
        bp_io_scratch_responder_pkg::bp_mem_msg_e msg_type; \
    } bp_mem_msg_s

// File: rtl/bp_io_scratch_responder_if.sv
// bp_io_scratch_responder_if: BP I/O command/response channel.
// The command side uses a valid/ready handshake. The response side uses valid/yumi.
// The master is the initiator (core io_cmd_o side). The slave is the responder.
interface bp_io_scratch_responder_if #(
    parameter int msg_width_p = 126
);
    logic [msg_width_p-1:0] io_cmd;
    logic                   io_cmd_v;
    logic                   io_cmd_ready;
    logic [msg_width_p-1:0] io_resp;
    logic                   io_resp_v;
    logic                   io_resp_yumi;

    modport master (
        output io_cmd, io_cmd_v, io_resp_yumi,
        input  io_cmd_ready, io_resp, io_resp_v
    );

    modport slave (
        input  io_cmd, io_cmd_v, io_resp_yumi,
        output io_cmd_ready, io_resp, io_resp_v
    );
endinterface

// File: rtl/bp_io_scratch_responder_regfile.sv
// bp_io_scratch_responder_regfile: els_p x 64-bit scratch bank. It has a
// byte-masked write port and a combinational read port.
// With BP_IO_SCRATCH_STATS_EN defined, the top two indices become read-only
// completion counters: els_p-2 counts reads and els_p-1 counts writes.
module bp_io_scratch_responder_regfile #(
    parameter  int data_width_p = 64,
    parameter  int els_p        = 16,
    localparam int lg_els_lp    = $clog2(els_p),
    localparam int bytes_lp     = data_width_p / 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_v,
    input  logic [lg_els_lp-1:0]    w_idx,
    input  logic [bytes_lp-1:0]     w_mask,
    input  logic [data_width_p-1:0] w_data,
    input  logic [lg_els_lp-1:0]    r_idx,
    output logic [data_width_p-1:0] r_data
`ifdef BP_IO_SCRATCH_STATS_EN
   ,input  logic                    rd_done,
    input  logic                    wr_done
`endif
);

    logic [data_width_p-1:0] regs_q [els_p];
    logic                    w_blocked;

`ifdef BP_IO_SCRATCH_STATS_EN
    localparam logic [lg_els_lp-1:0] rd_cnt_idx_lp = lg_els_lp'(els_p - 2);
    localparam logic [lg_els_lp-1:0] wr_cnt_idx_lp = lg_els_lp'(els_p - 1);

    logic [data_width_p-1:0] rd_cnt_q, wr_cnt_q;

    assign w_blocked = (w_idx >= rd_cnt_idx_lp);

    // Completion counters; wrap naturally at 2^64.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_done) rd_cnt_q <= rd_cnt_q + data_width_p'(1);
            if (wr_done) wr_cnt_q <= wr_cnt_q + data_width_p'(1);
        end
    end

    // Read port, with counters overlaying the top two indices.
    always_comb begin
        r_data = regs_q[r_idx];
        if (r_idx == rd_cnt_idx_lp) begin
            r_data = rd_cnt_q;
        end else if (r_idx == wr_cnt_idx_lp) begin
            r_data = wr_cnt_q;
        end
    end
`else
    assign w_blocked = 1'b0;
    assign r_data    = regs_q[r_idx];
`endif

    // Byte-masked write; the whole bank is cleared by reset.
    // NOTE: state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: the bank is reset explicitly (mailbox must read 0 after reset), which
    // keeps it in flops rather than an inferred RAM without reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_v && !w_blocked) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (w_mask[b]) begin
                    regs_q[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/bp_io_scratch_responder.sv
// bp_io_scratch_responder: responder end of the BP I/O command/response port.
// It takes one command at a time (READY -> ACCESS -> RESP) and services it
// against a local scratch register bank. It returns exactly one response per command.
// Optional macro BP_IO_SCRATCH_STATS_EN turns the top two registers into
// read-only completion counters.
module bp_io_scratch_responder
    import bp_io_scratch_responder_pkg::*;
#(
    parameter  int                       paddr_width_p    = 40,
    parameter  int                       data_width_p     = 64,
    parameter  int                       els_p            = 16,
    parameter  logic [paddr_width_p-1:0] base_addr_p      = 40'h00_0030_0000,
    localparam int                       mem_msg_width_lp = mem_msg_width(paddr_width_p, data_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_io_scratch_responder_if.slave io
);

    `DECLARE_BP_MEM_MSG_S(paddr_width_p, data_width_p);

    localparam int lg_els_lp = $clog2(els_p);

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_access = 2'd1,
        e_resp   = 2'd2
    } state_e;

    state_e                    state_q, state_n;
    logic [mem_msg_width_lp-1:0] cmd_raw;
    bp_mem_msg_s               cmd_in, cmd_q, resp_q, resp_n;
    logic                      cmd_ready, resp_v, cmd_accept;

    logic                      addr_hit;
    logic [lg_els_lp-1:0]      reg_idx;
    logic [2:0]                byte_off;
    logic [7:0]                size_mask, byte_mask;
    logic [data_width_p-1:0]   w_data, r_raw, r_data;
    logic                      w_v;

    assign cmd_raw = io.io_cmd;
    assign cmd_in  = cmd_raw;

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_n   = state_q;
        cmd_ready = 1'b0;
        resp_v    = 1'b0;
        unique case (state_q)
            e_ready: begin
                cmd_ready = 1'b1;
                if (io.io_cmd_v) state_n = e_access;
            end
            e_access: begin
                state_n = e_resp;
            end
            e_resp: begin
                resp_v = 1'b1;
                if (io.io_resp_yumi) state_n = e_ready;
            end
            default: begin
                state_n = e_ready;
            end
        endcase
    end

    assign cmd_accept      = cmd_ready && io.io_cmd_v;
    assign io.io_cmd_ready = cmd_ready && !reset_i;
    assign io.io_resp_v    = resp_v && !reset_i;
    assign io.io_resp      = resp_q;

    // State, 1-entry command buffer and response output register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            cmd_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_n;
            if (cmd_accept)           cmd_q  <= cmd_in;
            if (state_q == e_access)  resp_q <= resp_n;
        end
    end

    // Address decode, byte lane alignment and response assembly.
    always_comb begin
        addr_hit    = (cmd_q.addr[paddr_width_p-1:3+lg_els_lp]
                       == base_addr_p[paddr_width_p-1:3+lg_els_lp]);
        reg_idx     = cmd_q.addr[3 +: lg_els_lp];
        byte_off    = cmd_q.addr[2:0] & offset_align_mask(cmd_q.size);
        size_mask   = size_byte_mask(cmd_q.size);
        byte_mask   = size_mask << byte_off;
        w_data      = cmd_q.data << {byte_off, 3'b000};
        r_data      = (r_raw >> {byte_off, 3'b000}) & expand_byte_mask(size_mask);
        resp_n      = cmd_q;
        resp_n.data = (is_read_class(cmd_q.msg_type) && addr_hit) ? r_data : '0;
    end

    assign w_v = (state_q == e_access) && addr_hit && is_write_type(cmd_q.msg_type);

`ifdef BP_IO_SCRATCH_STATS_EN
    logic resp_done;
    assign resp_done = (state_q == e_resp) && io.io_resp_yumi && !reset_i;
`endif

    bp_io_scratch_responder_regfile #(
        .data_width_p (data_width_p),
        .els_p        (els_p)
    ) regfile (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .w_v     (w_v),
        .w_idx   (reg_idx),
        .w_mask  (byte_mask),
        .w_data  (w_data),
        .r_idx   (reg_idx),
        .r_data  (r_raw)
`ifdef BP_IO_SCRATCH_STATS_EN
       ,.rd_done (resp_done && is_read_class(cmd_q.msg_type)),
        .wr_done (resp_done && !is_read_class(cmd_q.msg_type))
`endif
    );

endmodule

// File: tb/tb_bp_io_scratch_responder.sv
// tb_bp_io_scratch_responder: randomized and directed stimulus for the I/O
// scratch responder, checked against a byte-level reference model.
// Honours BP_IO_SCRATCH_STATS_EN.
module tb_bp_io_scratch_responder;
    import bp_io_scratch_responder_pkg::*;

    localparam int          PADDR_W = 40;
    localparam int          ELS     = 16;
    localparam int          LG_ELS  = 4;
    localparam logic [39:0] BASE    = 40'h00_0030_0000;
    localparam int          PL_W    = mem_payload_width_gp;
    localparam int          MSG_W   = mem_msg_width(PADDR_W, 64);

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    bp_io_scratch_responder_if #(.msg_width_p(MSG_W)) io_if ();

    bp_io_scratch_responder #(
        .paddr_width_p (PADDR_W),
        .data_width_p  (64),
        .els_p         (ELS),
        .base_addr_p   (BASE)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .io      (io_if)
    );

    // Reference model: register contents and completion counts.
    logic [63:0] m_regs [ELS];
    logic [63:0] m_rd_cnt, m_wr_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ELS; i++) m_regs[i] = '0;
        m_rd_cnt = '0;
        m_wr_cnt = '0;
    endtask

    function automatic bit m_is_read(logic [3:0] mt);
        return (mt == e_mem_msg_rd) || (mt == e_mem_msg_uc_rd);
    endfunction

    function automatic logic [63:0] m_reg_value(int idx);
`ifdef BP_IO_SCRATCH_STATS_EN
        if (idx == ELS - 2) return m_rd_cnt;
        if (idx == ELS - 1) return m_wr_cnt;
`endif
        return m_regs[idx];
    endfunction

    // Apply one command to the model and return the expected response data.
    task automatic model_apply(input logic [3:0] mt, input logic [39:0] addr, input logic [1:0] sz,
                               input logic [63:0] data, output logic [63:0] exp_data);
        int          n, off, idx;
        bit          hit, writable;
        logic [63:0] v;
        n        = 1 << sz;
        off      = (int'(addr % 40'd8) / n) * n;
        idx      = int'((addr / 40'd8) % 40'(ELS));
        hit      = (addr / 40'(8 * ELS)) == (BASE / 40'(8 * ELS));
        exp_data = '0;
        writable = 1'b1;
`ifdef BP_IO_SCRATCH_STATS_EN
        if (idx >= ELS - 2) writable = 1'b0;
`endif
        if (hit && m_is_read(mt)) begin
            v = m_reg_value(idx);
            for (int b = 0; b < n; b++) exp_data[8*b +: 8] = v[8*(off+b) +: 8];
        end else if (hit && writable && (mt == e_mem_msg_wr || mt == e_mem_msg_uc_wr)) begin
            for (int b = 0; b < n; b++) m_regs[idx][8*(off+b) +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic drive_junk();
        logic [127:0] junk;
        junk = {$urandom, $urandom, $urandom, $urandom};
        io_if.io_cmd = junk[MSG_W-1:0];
    endtask

    // Full transaction starting from an idle READY cycle (called at posedge+1).
    task automatic send(input logic [3:0] mt, input logic [39:0] addr, input logic [1:0] sz,
                        input logic [63:0] data, input logic [PL_W-1:0] pl, input int stall,
                        output logic [63:0] rdata);
        logic [63:0]      exp_data;
        logic [MSG_W-1:0] exp_resp;
        check("cmd_ready_idle", io_if.io_cmd_ready, 1);
        io_if.io_cmd   = {data, pl, sz, addr, mt};
        io_if.io_cmd_v = 1'b1;
        model_apply(mt, addr, sz, data, exp_data);
        exp_resp = {exp_data, pl, sz, addr, mt};
        @(posedge clk_i); #1;
        io_if.io_cmd_v = 1'b0;
        drive_junk();
        check("resp_v_n1", io_if.io_resp_v, 0);
        check("cmd_ready_n1", io_if.io_cmd_ready, 0);
        @(posedge clk_i); #1;
        check("resp_v_n2", io_if.io_resp_v, 1);
        check("cmd_ready_n2", io_if.io_cmd_ready, 0);
        check("resp_msg", io_if.io_resp, exp_resp);
        rdata = io_if.io_resp[MSG_W-1 -: 64];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk_i); #1;
            check("resp_hold", io_if.io_resp, exp_resp);
            check("resp_v_hold", io_if.io_resp_v, 1);
            check("cmd_ready_hold", io_if.io_cmd_ready, 0);
        end
        io_if.io_resp_yumi = 1'b1;
        @(posedge clk_i); #1;
        io_if.io_resp_yumi = 1'b0;
        if (m_is_read(mt)) m_rd_cnt = m_rd_cnt + 64'd1;
        else               m_wr_cnt = m_wr_cnt + 64'd1;
        check("cmd_ready_after_yumi", io_if.io_cmd_ready, 1);
        check("resp_v_after_yumi", io_if.io_resp_v, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0]     rd;
        logic [3:0]      mt;
        logic [39:0]     addr;
        logic [PL_W-1:0] pl;

        io_if.io_cmd       = '0;
        io_if.io_cmd_v     = 1'b0;
        io_if.io_resp_yumi = 1'b0;
        reset_i            = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd_ready", io_if.io_cmd_ready, 0);
        check("rst_resp_v", io_if.io_resp_v, 0);
        check("rst_resp", io_if.io_resp, '0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("cmd_ready_first", io_if.io_cmd_ready, 1);

        // Sub-word write then full and half reads.
        send(e_mem_msg_uc_wr, BASE + 40'h0B, 2'd0, 64'h0000_0000_0000_00A5, '0, 0, rd);
        check("wr_resp_data", rd, 64'h0);
        send(e_mem_msg_uc_rd, BASE + 40'h08, 2'd3, 64'h1234, '0, 0, rd);
        check("byte_rd_full", rd, 64'h0000_0000_A500_0000);
        send(e_mem_msg_uc_rd, BASE + 40'h0A, 2'd1, 64'h0, '0, 0, rd);
        check("half_rd", rd, 64'hA500);

        // Full-width write/read.
        send(e_mem_msg_uc_wr, BASE + 40'h08, 2'd3, 64'hDEAD_BEEF_0123_4567, 16'h0001, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h08, 2'd3, 64'h0, 16'h0002, 0, rd);
        check("dword_rd", rd, 64'hDEAD_BEEF_0123_4567);

        // Address miss.
        send(e_mem_msg_uc_wr, BASE + 40'h1000, 2'd3, 64'h1, '0, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h1000, 2'd3, 64'h0, '0, 0, rd);
        check("miss_rd", rd, 64'h0);
        send(e_mem_msg_uc_rd, BASE, 2'd3, 64'h0, '0, 0, rd);
        check("reg0_untouched", rd, 64'h0);

        // Backpressure and payload echo.
        send(e_mem_msg_uc_rd, BASE + 40'h08, 2'd3, 64'h0, 16'h5A5A, 10, rd);
        send(e_mem_msg_uc_wr, BASE + 40'h18, 2'd2, 64'hCAFE_F00D_8765_4321, '1, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h18, 2'd2, 64'hFFFF_0000_FFFF_0000, '1, 0, rd);
        check("word_rd", rd, 64'h8765_4321);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0: mt = e_mem_msg_rd;
                1: mt = e_mem_msg_wr;
                2: mt = e_mem_msg_uc_rd;
                3: mt = e_mem_msg_uc_wr;
                4: mt = 4'($urandom_range(4, 15));
                default: mt = e_mem_msg_uc_rd;
            endcase
            addr = BASE + 40'($urandom_range(0, ELS * 8 - 1));
            if ($urandom_range(0, 4) == 0) addr = addr ^ (40'h1 << $urandom_range(LG_ELS + 3, PADDR_W - 1));
            pl = PL_W'($urandom);
            send(mt, addr, 2'($urandom_range(0, 3)), {$urandom, $urandom}, pl,
                 $urandom_range(0, 3), rd);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                drive_junk();
                @(posedge clk_i); #1;
                check("idle_cmd_ready", io_if.io_cmd_ready, 1);
                check("idle_resp_v", io_if.io_resp_v, 0);
            end
        end

        // Reset while a command sits in ACCESS.
        send(e_mem_msg_uc_wr, BASE + 40'h10, 2'd3, 64'h1111_2222_3333_4444, '0, 0, rd);
        io_if.io_cmd   = {64'h0, 16'h0, 2'd3, BASE + 40'h10, 4'(e_mem_msg_uc_rd)};
        io_if.io_cmd_v = 1'b1;
        @(posedge clk_i); #1;
        io_if.io_cmd_v = 1'b0;
        reset_i = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        check("midrst_resp_v", io_if.io_resp_v, 0);
        check("midrst_cmd_ready", io_if.io_cmd_ready, 0);
        reset_i = 1'b0;
        #1;
        check("postrst_cmd_ready", io_if.io_cmd_ready, 1);
        @(posedge clk_i); #1;
        check("postrst_resp_v", io_if.io_resp_v, 0);
        send(e_mem_msg_uc_rd, BASE + 40'h10, 2'd3, 64'h0, '0, 0, rd);
        check("postrst_rd", rd, 64'h0);

        // Three reads and two writes since reset, then counter indices.
        send(e_mem_msg_uc_rd, BASE, 2'd3, 64'h0, '0, 0, rd);
        send(e_mem_msg_rd, BASE + 40'h08, 2'd3, 64'h0, '0, 0, rd);
        send(e_mem_msg_uc_wr, BASE + 40'h20, 2'd3, 64'hAAAA, '0, 0, rd);
        send(e_mem_msg_wr, BASE + 40'h28, 2'd3, 64'hBBBB, '0, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h70, 2'd3, 64'h0, '0, 0, rd);
`ifdef BP_IO_SCRATCH_STATS_EN
        check("stats_rd_cnt", rd, 64'd3);
`endif
        send(e_mem_msg_uc_rd, BASE + 40'h78, 2'd3, 64'h0, '0, 0, rd);
`ifdef BP_IO_SCRATCH_STATS_EN
        check("stats_wr_cnt", rd, 64'd2);
`endif
        send(e_mem_msg_uc_wr, BASE + 40'h70, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h70, 2'd3, 64'h0, '0, 0, rd);
        send(e_mem_msg_uc_rd, BASE + 40'h28, 2'd1, 64'h0, '0, 0, rd);
        check("rd_after_stats", rd, 64'hBBBB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
